// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter: round-robin grant, read-to-write turnaround bubble and read-return routing.
// Optional build macro SRAM_ARB_FIXED_PRIO_EN gives port 0 fixed priority under contention.
module sram_arbiter #(
    parameter int READ_LAT = 2,
    parameter int AW       = 20,
    parameter int DW       = 16
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic          p0_req,
    input  logic          p0_wen,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_din,
    output logic          p0_ack,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_wen,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_din,
    output logic          p1_ack,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          sram_wen,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_din,
    input  logic [DW-1:0] sram_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic          last_grant_reg, last_grant_next;

    logic          win_port;
    logic          win_wen;
    logic          any_req;
    logic          turnaround;
    logic          grant;

    logic          sram_wen_reg;
    logic [AW-1:0] sram_addr_reg;
    logic [DW-1:0] sram_din_reg;
    logic          cmd_rd_reg;
    logic          cmd_port_reg;

    logic [READ_LAT-1:0] pipe_valid_reg;
    logic [READ_LAT-1:0] pipe_port_reg;

    // Winner is picked before the turnaround gate so a blocked write is not
    // bypassed by a read from the other port in the same cycle.
    always_comb begin
        win_port        = 1'b0;
        any_req         = p0_req | p1_req;
        if (p0_req && p1_req) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            win_port = 1'b0;
`else
            win_port = ~last_grant_reg;
`endif
        end else if (p1_req) begin
            win_port = 1'b1;
        end
        win_wen         = win_port ? p1_wen : p0_wen;
        turnaround      = (state_reg == RD) && win_wen;
        grant           = any_req && !turnaround && aresetn;
        p0_ack          = grant && !win_port;
        p1_ack          = grant && win_port;
        state_next      = IDLE;
        if (grant) begin
            state_next = win_wen ? WR : RD;
        end
        last_grant_next = grant ? win_port : last_grant_reg;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // Without a grant the wrapper sees a harmless read of the held address.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sram_wen_reg  <= 1'b0;
            sram_addr_reg <= '0;
            sram_din_reg  <= '0;
            cmd_rd_reg    <= 1'b0;
            cmd_port_reg  <= 1'b0;
        end else begin
            sram_wen_reg <= grant && win_wen;
            cmd_rd_reg   <= grant && !win_wen;
            cmd_port_reg <= win_port;
            if (grant) begin
                sram_addr_reg <= win_port ? p1_addr : p0_addr;
                sram_din_reg  <= win_port ? p1_din  : p0_din;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < READ_LAT; gi++) begin : g_ret
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge aresetn) begin
                    if (!aresetn) begin
                        pipe_valid_reg[gi] <= 1'b0;
                        pipe_port_reg[gi]  <= 1'b0;
                    end else begin
                        pipe_valid_reg[gi] <= cmd_rd_reg;
                        pipe_port_reg[gi]  <= cmd_port_reg;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or negedge aresetn) begin
                    if (!aresetn) begin
                        pipe_valid_reg[gi] <= 1'b0;
                        pipe_port_reg[gi]  <= 1'b0;
                    end else begin
                        pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
                        pipe_port_reg[gi]  <= pipe_port_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign sram_wen  = sram_wen_reg;
    assign sram_addr = sram_addr_reg;
    assign sram_din  = sram_din_reg;

    assign p0_rvalid = pipe_valid_reg[READ_LAT-1] && !pipe_port_reg[READ_LAT-1];
    assign p1_rvalid = pipe_valid_reg[READ_LAT-1] &&  pipe_port_reg[READ_LAT-1];
    assign p0_rdata  = sram_dout;
    assign p1_rdata  = sram_dout;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: reset, vector table, hand sequences and a random run against a rule-level model.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        p0_req, p0_wen, p1_req, p1_wen;
    logic [19:0] p0_addr, p1_addr;
    logic [15:0] p0_din, p1_din;
    logic        p0_ack, p1_ack, p0_rvalid, p1_rvalid;
    logic [15:0] p0_rdata, p1_rdata;
    logic        sram_wen;
    logic [19:0] sram_addr;
    logic [15:0] sram_din;
    logic [15:0] sram_dout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk(clk), .aresetn(aresetn),
        .p0_req(p0_req), .p0_wen(p0_wen), .p0_addr(p0_addr), .p0_din(p0_din),
        .p0_ack(p0_ack), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_wen(p1_wen), .p1_addr(p1_addr), .p1_din(p1_din),
        .p1_ack(p1_ack), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_din(sram_din),
        .sram_dout(sram_dout)
    );

    // SRAM wrapper stand-in: data appears two cycles after the command.
    logic [15:0] mem [0:255];
    logic [15:0] rd_d1;
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        rd_d1     = 16'h0;
        sram_dout = 16'h0;
    end
    always @(posedge clk) begin
        if (sram_wen) mem[sram_addr[7:0]] <= sram_din;
        rd_d1     <= mem[sram_addr[7:0]];
        sram_dout <= rd_d1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [19:0] a0, input logic [15:0] d0,
                         input logic r1, input logic w1, input logic [19:0] a1, input logic [15:0] d1);
        p0_req = r0; p0_wen = w0; p0_addr = a0; p0_din = d0;
        p1_req = r1; p1_wen = w1; p1_addr = a1; p1_din = d1;
    endtask

    task automatic idle_in();
        drive(0, 0, 20'h0, 16'h0, 0, 0, 20'h0, 16'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        aresetn = 1'b0;
        idle_in();
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
    endtask

    typedef struct {
        logic        r0, w0;
        logic [19:0] a0;
        logic [15:0] d0;
        logic        r1, w1;
        logic [19:0] a1;
        logic [15:0] d1;
        logic        e_ack0, e_ack1, e_wen;
        logic [19:0] e_addr;
    } vec_t;

    vec_t tbl [8];

    typedef struct {
        int          due;
        logic        port;
        logic [15:0] data;
    } ret_t;

    initial begin
        logic seen;
        int   k;
        aresetn = 1'b0;
        idle_in();

        // Reset held with both requests up: nothing may escape.
        drive(1, 0, 20'h00020, 16'h0, 1, 0, 20'h00030, 16'h0);
        repeat (3) @(negedge clk);
        chk("rst_ack0", p0_ack, 0);
        chk("rst_ack1", p1_ack, 0);
        chk("rst_wen", sram_wen, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_din", sram_din, 0);
        chk("rst_rv0", p0_rvalid, 0);
        chk("rst_rv1", p1_rvalid, 0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        @(negedge clk);
        chk("rst_rel_ack0", p0_ack, 1);
        chk("rst_rel_ack1", p1_ack, 0);
        $display("txn reset release: p0_ack=%0d p1_ack=%0d", p0_ack, p1_ack);
        @(posedge clk); #1;
        idle_in();
        repeat (4) @(posedge clk);
        #1;

        // Single write then read-back.
        drive(1, 1, 20'h00010, 16'hBEEF, 0, 0, 20'h0, 16'h0);
        @(negedge clk);
        chk("wr_ack", p0_ack, 1);
        @(posedge clk); #1;
        idle_in();
        @(negedge clk);
        chk("wr_cmd_wen", sram_wen, 1);
        chk("wr_cmd_addr", sram_addr, 20'h00010);
        chk("wr_cmd_din", sram_din, 16'hBEEF);
        @(negedge clk);
        chk("wr_cmd_done", sram_wen, 0);
        $display("txn p0 write addr=00010 din=beef");
        @(posedge clk); #1;
        drive(0, 0, 20'h0, 16'h0, 1, 0, 20'h00010, 16'h0);
        @(negedge clk);
        chk("rd_ack", p1_ack, 1);
        for (k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            idle_in();
            @(negedge clk);
            chk($sformatf("rd_rv1_k%0d", k), p1_rvalid, (k == 3) ? 1 : 0);
            chk($sformatf("rd_rv0_k%0d", k), p0_rvalid, 0);
            if (k == 3) chk("rd_data", p1_rdata, 16'hBEEF);
        end
        $display("txn p1 read addr=00010 data=%h", 16'hBEEF);

        // Vector table: contention, turnaround bubble, write-to-read with no bubble.
        tbl[0] = '{1, 0, 20'h100, 16'h0, 1, 0, 20'h200, 16'h0,    1, 0, 0, 20'h0};
`ifdef SRAM_ARB_FIXED_PRIO_EN
        tbl[1] = '{1, 0, 20'h101, 16'h0, 1, 0, 20'h200, 16'h0,    1, 0, 0, 20'h100};
        tbl[2] = '{1, 0, 20'h102, 16'h0, 1, 1, 20'h300, 16'h5555, 1, 0, 0, 20'h101};
`else
        tbl[1] = '{1, 0, 20'h101, 16'h0, 1, 0, 20'h200, 16'h0,    0, 1, 0, 20'h100};
        tbl[2] = '{1, 0, 20'h102, 16'h0, 1, 1, 20'h300, 16'h5555, 1, 0, 0, 20'h200};
`endif
        tbl[3] = '{0, 0, 20'h0,   16'h0, 1, 1, 20'h300, 16'h5555, 0, 0, 0, 20'h102};
        tbl[4] = '{0, 0, 20'h0,   16'h0, 1, 1, 20'h300, 16'h5555, 0, 1, 0, 20'h102};
        tbl[5] = '{1, 0, 20'h105, 16'h0, 0, 0, 20'h0,   16'h0,    1, 0, 1, 20'h300};
        tbl[6] = '{0, 0, 20'h0,   16'h0, 0, 0, 20'h0,   16'h0,    0, 0, 0, 20'h105};
        tbl[7] = '{0, 0, 20'h0,   16'h0, 0, 0, 20'h0,   16'h0,    0, 0, 0, 20'h105};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            @(negedge clk);
            chk($sformatf("tbl%0d_ack0", i), p0_ack, tbl[i].e_ack0);
            chk($sformatf("tbl%0d_ack1", i), p1_ack, tbl[i].e_ack1);
            chk($sformatf("tbl%0d_wen", i), sram_wen, tbl[i].e_wen);
            chk($sformatf("tbl%0d_addr", i), sram_addr, tbl[i].e_addr);
            $display("txn vec %0d: ack0=%0d ack1=%0d wen=%0d addr=%h", i, p0_ack, p1_ack, sram_wen, sram_addr);
        end

        // Reset pulse one cycle after a read is acked: its return must vanish.
        do_reset();
        @(posedge clk); #1;
        drive(0, 0, 20'h0, 16'h0, 1, 0, 20'h00010, 16'h0);
        @(negedge clk);
        chk("rstrd_ack", p1_ack, 1);
        @(posedge clk); #1;
        idle_in();
        #1 aresetn = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (p1_rvalid || p0_rvalid) seen = 1'b1;
        end
        chk("rstrd_no_rvalid", seen, 0);
        $display("txn reset during read: rvalid seen=%0d", seen);

        // Random run against a rule-level model.
        begin
            logic [15:0] shadow [0:255];
            ret_t        pend [$];
            logic        m_prev_rd, m_lg, e_wen, e_rv0, e_rv1;
            logic [19:0] e_addr;
            logic [15:0] e_din, e_data;
            logic        q_req [2];
            logic        q_wen [2];
            logic [19:0] q_addr [2];
            logic [15:0] q_din [2];
            logic        m_ack [2];
            int          win;

            do_reset();
            for (int i = 0; i < 256; i++) shadow[i] = mem[i];
            m_prev_rd = 0; m_lg = 1; e_wen = 0; e_addr = 0; e_din = 0;
            for (int p = 0; p < 2; p++) begin
                q_req[p] = 0; q_wen[p] = 0; q_addr[p] = 0; q_din[p] = 0; m_ack[p] = 0;
            end
            for (int cyc = 0; cyc < 800; cyc++) begin
                @(posedge clk); #1;
                for (int p = 0; p < 2; p++) begin
                    if (m_ack[p]) q_req[p] = 0;
                    if (!q_req[p] && ($urandom_range(0, 9) < 6)) begin
                        q_req[p]  = 1;
                        q_wen[p]  = ($urandom_range(0, 2) == 0);
                        q_addr[p] = 20'($urandom_range(0, 15)) | (20'($urandom_range(0, 3)) << 16);
                        q_din[p]  = 16'($urandom);
                    end
                end
                drive(q_req[0], q_wen[0], q_addr[0], q_din[0], q_req[1], q_wen[1], q_addr[1], q_din[1]);
                @(negedge clk);

                win = -1;
                if (q_req[0] && q_req[1]) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
                    win = 0;
`else
                    win = m_lg ? 0 : 1;
`endif
                end else if (q_req[0]) win = 0;
                else if (q_req[1]) win = 1;
                if (win >= 0 && m_prev_rd && q_wen[win]) win = -1;
                m_ack[0] = (win == 0);
                m_ack[1] = (win == 1);

                e_rv0 = 0; e_rv1 = 0; e_data = 16'h0;
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    if (pend[0].port) e_rv1 = 1; else e_rv0 = 1;
                    e_data = pend[0].data;
                    void'(pend.pop_front());
                end

                chk($sformatf("rnd%0d_ack0", cyc), p0_ack, m_ack[0]);
                chk($sformatf("rnd%0d_ack1", cyc), p1_ack, m_ack[1]);
                chk($sformatf("rnd%0d_wen", cyc), sram_wen, e_wen);
                chk($sformatf("rnd%0d_addr", cyc), sram_addr, e_addr);
                chk($sformatf("rnd%0d_din", cyc), sram_din, e_din);
                chk($sformatf("rnd%0d_rv0", cyc), p0_rvalid, e_rv0);
                chk($sformatf("rnd%0d_rv1", cyc), p1_rvalid, e_rv1);
                if (e_rv0) chk($sformatf("rnd%0d_rdata0", cyc), p0_rdata, e_data);
                if (e_rv1) chk($sformatf("rnd%0d_rdata1", cyc), p1_rdata, e_data);

                e_wen     = 0;
                m_prev_rd = 0;
                if (win >= 0) begin
                    $display("txn cyc=%0d port=%0d %s addr=%h din=%h", cyc, win,
                             q_wen[win] ? "wr" : "rd", q_addr[win], q_din[win]);
                    if (q_wen[win]) begin
                        shadow[q_addr[win][7:0]] = q_din[win];
                    end else begin
                        pend.push_back('{cyc + 3, logic'(win), shadow[q_addr[win][7:0]]});
                        m_prev_rd = 1;
                    end
                    e_wen  = q_wen[win];
                    e_addr = q_addr[win];
                    e_din  = q_din[win];
                    m_lg   = logic'(win);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
